// File: rtl/serial_compare_nbit_pkg.sv
// Shared types and defaults for the MSB-first serial magnitude comparator.
package serial_compare_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sc_state_t;

   localparam int SC_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_compare_nbit.sv
// Serial unsigned comparator: walks both operands MSB first, one bit pair per
// cycle, stopping at the first differing pair.
module serial_compare_nbit
   import serial_compare_pkg::*;
#(
   parameter int WIDTH = SC_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             esit,
   output logic             buyuk,
   output logic             kucuk
);

   localparam int            CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   sc_state_t        state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             esit_q, esit_d;
   logic             buyuk_q, buyuk_d;
   logic             kucuk_q, kucuk_d;
   logic             msb_a, msb_b;

   assign msb_a = sa_q[WIDTH-1];
   assign msb_b = sb_q[WIDTH-1];

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      esit_d  = esit_q;
      buyuk_d = buyuk_q;
      kucuk_d = kucuk_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               cnt_d   = CNT_TOP;
               esit_d  = 1'b0;
               buyuk_d = 1'b0;
               kucuk_d = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // The first differing pair decides the magnitude outright.
            if (msb_a != msb_b) begin
               buyuk_d = msb_a & ~msb_b;
               kucuk_d = ~msb_a & msb_b;
               esit_d  = 1'b0;
               state_d = DONE;
            end else if (cnt_q == '0) begin
               esit_d  = 1'b1;
               buyuk_d = 1'b0;
               kucuk_d = 1'b0;
               state_d = DONE;
            end else begin
               sa_d  = sa_q << 1;
               sb_d  = sb_q << 1;
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         esit_q  <= 1'b0;
         buyuk_q <= 1'b0;
         kucuk_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         esit_q  <= esit_d;
         buyuk_q <= buyuk_d;
         kucuk_q <= kucuk_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q == SHIFT);
   assign done  = (state_q == DONE);
   assign esit  = esit_q;
   assign buyuk = buyuk_q;
   assign kucuk = kucuk_q;

endmodule

// File: tb/tb_serial_compare_nbit.sv
// Bench for serial_compare_nbit: arithmetic reference model plus directed vectors.
module tb_serial_compare_nbit;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready, busy, done, esit, buyuk, kucuk;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   serial_compare_nbit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .esit  (esit),
      .buyuk (buyuk),
      .kucuk (kucuk)
   );

   always #5 clk = ~clk;

   // Bit pairs examined: position of first differing bit from the MSB, else all W.
   function automatic int k_of(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int i = W - 1; i >= 0; i--)
         if (x[i] != y[i]) return W - i;
      return W;
   endfunction

   function automatic logic [2:0] res_of(input logic [W-1:0] x, input logic [W-1:0] y);
      return {x == y, x > y, x < y};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, got, exp);
   endtask

   // Reference model: counts down k cycles after acceptance, then a one-cycle done.
   logic       m_ready, m_busy, m_done;
   logic [2:0] m_res, m_pend;
   int         m_rem;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready <= 1'b1;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_res   <= '0;
         m_pend  <= '0;
         m_rem   <= 0;
      end else if (m_ready) begin
         if (start) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_res   <= '0;
            m_rem   <= k_of(a, b);
            m_pend  <= res_of(a, b);
         end
      end else if (m_busy) begin
         if (m_rem == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
         m_rem <= m_rem - 1;
      end else if (m_done) begin
         m_done  <= 1'b0;
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en)
         chk("cycle", {ready, busy, done, esit, buyuk, kucuk},
             {m_ready, m_busy, m_done, m_res});
   end

   task automatic wait_done(input int c0, output int cyc, output bit ok);
      cyc = c0;
      ok  = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         cyc++;
         if (done) ok = 1'b1;
      end
      if (!ok) begin
         n_total++;
         $display("FAIL done_timeout: no done pulse seen, required one within 40 cycles");
      end
   endtask

   task automatic do_cmp(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input int exp_k, input logic [2:0] exp_r, input string nm);
      int cyc;
      bit ok;
      @(posedge clk); #1;
      a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(0, cyc, ok);
      if (ok) begin
         chk({nm, "_lat"}, cyc, exp_k + 1);
         chk({nm, "_res"}, {esit, buyuk, kucuk}, exp_r);
      end
   endtask

   initial begin
      int  cyc, last, npulse;
      bit  ok;

      chk("model_k_eq",  k_of(8'hA5, 8'hA5), 8);
      chk("model_k_msb", k_of(8'h80, 8'h7F), 1);
      chk("model_k_lsb", k_of(8'h12, 8'h13), 8);
      chk("model_k_7",   k_of(8'h01, 8'h02), 7);
      chk("model_r_gt",  res_of(8'h0F, 8'h0E), 3'b010);

      #2 rst_n = 1'b0;
      #1 chk("reset_state", {ready, busy, done, esit, buyuk, kucuk}, 6'b100000);
      cmp_en = 1'b1;
      #19 rst_n = 1'b1;

      do_cmp(8'hA5, 8'hA5, 8, 3'b100, "eq_a5");
      do_cmp(8'h80, 8'h7F, 1, 3'b010, "gt_msb");
      do_cmp(8'h12, 8'h13, 8, 3'b001, "lt_lsb");
      repeat (5) @(negedge clk);
      chk("hold5", {esit, buyuk, kucuk}, 3'b001);

      // Start while busy must be ignored; operand changes after acceptance too.
      @(posedge clk); #1;
      a = 8'h0F; b = 8'h0E; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 8'h33; b = 8'hCC;
      cyc = 0;
      repeat (3) begin @(negedge clk); cyc++; end
      @(posedge clk); #1;
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(negedge clk); cyc++;
      chk("busy_ignore", busy, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, cyc, ok);
      if (ok) begin
         chk("ignore_lat", cyc, 9);
         chk("ignore_res", {esit, buyuk, kucuk}, 3'b010);
      end
      do_cmp(8'h00, 8'h01, 8, 3'b001, "after_ready");

      // Reset in the middle of a SHIFT.
      @(posedge clk); #1;
      a = 8'h55; b = 8'h55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_shift_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {ready, busy, done, esit, buyuk, kucuk}, 6'b100000);
      #3 rst_n = 1'b1;
      do_cmp(8'h01, 8'h02, 7, 3'b001, "post_reset");

      // Continuous start: one result every k+2 = 3 cycles.
      @(posedge clk); #1;
      a = 8'h00; b = 8'hFF; start = 1'b1;
      last = 0;
      npulse = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            if (last > 0) chk("stream_gap", i - last, 3);
            chk("stream_res", {esit, buyuk, kucuk}, 3'b001);
            last = i;
            npulse++;
         end
      end
      start = 1'b0;
      chk("stream_count", npulse, 10);
      repeat (4) @(negedge clk);
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
